// File: rtl/tcam_pkg.sv
// Shared definitions for the TCAM update/lookup controller.
// The widths and the write-sweep length belong to the TCAM primitive in the parent.
// This controller has to stay aligned with that primitive.
package tcam_pkg;

   localparam int TCAM_DEPTH = 512;
   localparam int TCAM_WIDTH = 36;
   // Cycles the TCAM needs to rewrite one entry (one LUTRAM address sweep).
   localparam int WR_CYCLES  = 64;
   localparam int TCAM_AW    = $clog2(TCAM_DEPTH);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_t;

   typedef struct packed {
      logic [TCAM_AW-1:0]    addr;
      logic [TCAM_WIDTH-1:0] patt;
      logic [TCAM_WIDTH-1:0] mask;
   } upd_req_t;

endpackage

// File: rtl/tcam_update_ctrl.sv
// Sequences rule updates and lookups onto a LUTRAM-based TCAM.
// An update holds the write port for WR_CYCLES cycles while the TCAM sweeps its internal address counter.
// Lookups are blocked during that time.
// A shadow counter tracks the TCAM's internal sweep counter.
// Leaving WRITE on its terminal value guarantees that both counters are zero in IDLE.
// Lookups are pipelined with a fixed latency of 2 and can be issued every cycle.
module tcam_update_ctrl #(
   parameter int DEPTH     = tcam_pkg::TCAM_DEPTH,
   parameter int WIDTH     = tcam_pkg::TCAM_WIDTH,
   parameter int WR_CYCLES = tcam_pkg::WR_CYCLES
) (
   input  logic                     clk,
   input  logic                     rst_n,
   // update request
   input  logic                     upd_valid,
   output logic                     upd_ready,
   input  logic [$clog2(DEPTH)-1:0] upd_addr,
   input  logic [WIDTH-1:0]         upd_patt,
   input  logic [WIDTH-1:0]         upd_mask,
   output logic                     upd_done,
   // lookup request and result
   input  logic                     lkp_valid,
   output logic                     lkp_ready,
   input  logic [WIDTH-1:0]         lkp_key,
   output logic                     res_valid,
   output logic                     res_match,
   output logic [$clog2(DEPTH)-1:0] res_addr,
   output logic                     busy,
   // TCAM primitive interface
   output logic                     tcam_wEn,
   output logic [$clog2(DEPTH)-1:0] tcam_wAddr,
   output logic [WIDTH-1:0]         tcam_wPatt,
   output logic [WIDTH-1:0]         tcam_wMask,
   output logic [WIDTH-1:0]         tcam_mPatt,
   input  logic                     tcam_match,
   input  logic [$clog2(DEPTH)-1:0] tcam_mAddr
);

   import tcam_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(WR_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(WR_CYCLES - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_upd_ready;
   logic             w_lkp_ready;
   logic             w_upd_acc;
   logic             w_lkp_acc;
   logic             w_wr_last;

   logic [CW-1:0]    r_cnt;
   logic             r_wen;
   logic             r_busy;
   logic             r_done;
   logic [AW-1:0]    r_hold_addr;
   logic [WIDTH-1:0] r_hold_patt;
   logic [WIDTH-1:0] r_hold_mask;

   logic [WIDTH-1:0] r_mpatt;
   logic             r_lkp_p1;
   logic             r_res_valid;
   logic             r_res_match;
   logic [AW-1:0]    r_res_addr;

   // State register of the IDLE/WRITE controller.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, handshake readiness and accept decodes; an update beats a simultaneous lookup.
   always_comb begin
      w_state_nxt = r_state;
      w_upd_ready = 1'b0;
      w_lkp_ready = 1'b0;
      w_upd_acc   = 1'b0;
      w_lkp_acc   = 1'b0;
      w_wr_last   = 1'b0;
      case (r_state)
         IDLE: begin
            w_upd_ready = 1'b1;
            w_lkp_ready = !upd_valid;
            w_lkp_acc   = lkp_valid && !upd_valid;
            if (upd_valid) begin
               w_upd_acc   = 1'b1;
               w_state_nxt = WRITE;
            end else begin
               w_upd_acc   = 1'b0;
               w_state_nxt = IDLE;
            end
         end
         WRITE: begin
            if (r_cnt == CNT_LAST) begin
               w_wr_last   = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_wr_last   = 1'b0;
               w_state_nxt = WRITE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Write side: capture the request, run the shadow sweep counter, drive write enable and completion pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_wen       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_hold_addr <= '0;
         r_hold_patt <= '0;
         r_hold_mask <= '0;
      end else begin
         r_done <= w_wr_last;
         if (w_upd_acc) begin
            r_hold_addr <= upd_addr;
            r_hold_patt <= upd_patt;
            r_hold_mask <= upd_mask;
            r_cnt       <= '0;
            r_wen       <= 1'b1;
            r_busy      <= 1'b1;
         end else if (w_wr_last) begin
            r_cnt  <= '0;
            r_wen  <= 1'b0;
            r_busy <= 1'b0;
         end else if (r_wen) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Lookup pipeline: register the key, then sample the TCAM result one cycle later.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mpatt     <= '0;
         r_lkp_p1    <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_match <= 1'b0;
         r_res_addr  <= '0;
      end else begin
         if (w_lkp_acc) begin
            r_mpatt <= lkp_key;
         end
         r_lkp_p1    <= w_lkp_acc;
         r_res_valid <= r_lkp_p1;
         if (r_lkp_p1) begin
            r_res_match <= tcam_match;
            r_res_addr  <= tcam_mAddr;
         end
      end
   end

   assign upd_ready  = w_upd_ready;
   assign lkp_ready  = w_lkp_ready;
   assign upd_done   = r_done;
   assign busy       = r_busy;
   assign tcam_wEn   = r_wen;
   assign tcam_wAddr = r_hold_addr;
   assign tcam_wPatt = r_hold_patt;
   assign tcam_wMask = r_hold_mask;
   assign tcam_mPatt = r_mpatt;
   assign res_valid  = r_res_valid;
   assign res_match  = r_res_match;
   assign res_addr   = r_res_addr;

endmodule

// File: doc/tcam_update_ctrl.md
TCAM_UPDATE_CTRL -- requirements
Module: tcam_update_ctrl

Interface
REQ-001 Parameter DEPTH, default 512: number of TCAM entries.
REQ-002 Parameter WIDTH, default 36: key width, multiple of 18.
REQ-003 Parameter WR_CYCLES, default 64: LUTRAM sweep length, 2^6.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low; the same net also drives the TCAM reset.
REQ-006 upd_valid  in  1  update request valid.
REQ-007 upd_ready  out  1  update request accepted when high together with upd_valid.
REQ-008 upd_addr  in  clog2(DEPTH)  target entry of the update.
REQ-009 upd_patt / upd_mask  in  WIDTH each  rule pattern and mask.
REQ-010 upd_done  out  1  one-cycle pulse when an update completes.
REQ-011 lkp_valid  in  1  lookup request valid.
REQ-012 lkp_ready  out  1  lookup request accepted when high together with lkp_valid.
REQ-013 lkp_key  in  WIDTH  search key.
REQ-014 res_valid  out  1  one-cycle result strobe; no backpressure.
REQ-015 res_match  out  1  lookup hit.
REQ-016 res_addr  out  clog2(DEPTH)  lowest matching entry; valid with res_valid.
REQ-017 busy  out  1  high while the block is in the WRITE state.
REQ-018 tcam_wEn  out  1  TCAM write enable.
REQ-019 tcam_wAddr  out  clog2(DEPTH)  TCAM write address.
REQ-020 tcam_wPatt / tcam_wMask  out  WIDTH each  TCAM write pattern and mask.
REQ-021 tcam_mPatt  out  WIDTH  TCAM match key.
REQ-022 tcam_match  in  1  TCAM match indicator (combinational from tcam_mPatt).
REQ-023 tcam_mAddr  in  clog2(DEPTH)  TCAM matched address.

Function
REQ-024 States: IDLE and WRITE.
REQ-025 In IDLE, upd_ready = 1 and lkp_ready = !upd_valid; an update therefore wins over a simultaneous lookup, and at most one handshake occurs per cycle.
REQ-026 Update accept in cycle t:
- capture upd_addr, upd_patt and upd_mask into hold registers;
- go to WRITE at edge t.
REQ-027 In WRITE:
- tcam_wEn = 1 for exactly WR_CYCLES consecutive cycles, t+1 through t+WR_CYCLES;
- tcam_wAddr, tcam_wPatt and tcam_wMask are driven from the hold registers and stay stable throughout;
- upd_ready = 0 and lkp_ready = 0.
REQ-028 A 6-bit shadow counter starts at 0 on entry to WRITE and increments on every cycle tcam_wEn is high. On its terminal value 63 the block returns to IDLE, so the TCAM internal counter is again 0 whenever the block is in IDLE.
REQ-029 upd_done pulses in cycle t+WR_CYCLES+1, the first IDLE cycle after the write.
REQ-030 Lookup accept in cycle t:
- lkp_key is registered into tcam_mPatt at edge t;
- tcam_match and tcam_mAddr are registered at edge t+1;
- res_valid = 1 in cycle t+2, giving a fixed latency of 2.
REQ-031 Back-to-back lookups are accepted every cycle, giving one result per cycle.
REQ-032 An update accepted in cycle t+1 after a lookup accepted in cycle t does not corrupt that lookup, because the result is sampled before tcam_wEn rises.
REQ-033 tcam_wEn is never high in a cycle whose tcam_match is being sampled for a result.
REQ-034 tcam_mPatt holds its last value when no lookup is accepted.
REQ-035 Throughput: one update per WR_CYCLES+1 cycles.

Reset
REQ-036 With rst_n low at an edge, the following are 0 after that edge: state (IDLE), shadow counter, hold registers, tcam_mPatt, the result pipeline, tcam_wEn, upd_done, res_valid, res_match, res_addr and busy.
REQ-037 Reset during WRITE abandons the update with no upd_done pulse; the TCAM counter is reset by the same edge, so alignment is preserved.
REQ-038 upd_ready and lkp_ready follow REQ-025 in the first cycle after reset.

Structure
REQ-039 A shared package tcam_pkg holds:
- WR_CYCLES;
- the state enum (IDLE, WRITE);
- an update-request struct {addr, patt, mask} parameterised by the DEPTH and WIDTH localparams.
REQ-040 The block is a single module with no sub-modules; the TCAM instance lives in the parent.

Verification
REQ-041 Reset, then one update (addr=5, patt=36'h123456789) -> tcam_wEn high for exactly 64 cycles, upd_done in cycle 66 after accept, shadow counter back at 0.
REQ-042 Lookup with key 36'h123456789 after REQ-041 -> res_valid 2 cycles after accept, res_match=1, res_addr=5; with key 36'h0 -> res_match=0.
REQ-043 upd_valid and lkp_valid high in the same IDLE cycle -> update accepted, lkp_ready=0 for 65 cycles, then the lookup is accepted.
REQ-044 Lookups on 8 consecutive cycles, followed by an update in cycle 9 -> 8 results on consecutive cycles, all correct, with tcam_wEn rising no earlier than cycle 10.
REQ-045 rst_n low at write cycle 30 -> tcam_wEn=0 next cycle, no upd_done; a following update again produces exactly 64 write cycles and a correct lookup.
REQ-046 Two entries (addr 3 and addr 9) with the same pattern -> lookup returns res_addr=3.
